// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the fp multiplier scheduler.
//   - rm_e     : IEEE-754 rounding-mode encoding carried on the 3-bit rm buses
//   - FP32_*   : single-precision width constants
//   - fp32_t   : single-precision field view (sign, exponent, fraction)
// Port summary: none (package only).
package fp_pkg;

  localparam int FP32_W      = 32;
  localparam int FP32_EXP_W  = 8;
  localparam int FP32_FRAC_W = 23;
  localparam int RM_W        = 3;

  // Encodings 101..111 are not listed; the scheduler forwards them untouched,
  // so rm buses stay plain logic [RM_W-1:0] rather than this enum type.
  typedef enum logic [RM_W-1:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic                   sign;
    logic [FP32_EXP_W-1:0]  exp;
    logic [FP32_FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_mul_sched_rr_arb.sv
// rr_arb: round-robin selector for the fp multiplier scheduler.
// The search starts one position after last_grant and wraps modulo NREQ;
// the first eligible requester found wins. Purely combinational.
// Ports:
//   eligible   [NREQ-1:0] in  : requesters allowed to win this cycle
//   last_grant [IDW-1:0]  in  : index of the most recent accepted transfer
//   grant      [NREQ-1:0] out : one-hot winner, all zero when nobody is eligible
module rr_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(last_grant) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// fp_mul_sched: shares one external combinational fp32 multiplier between
// NREQ requesters (NREQ legal 2..4).
// Pipeline: ISSUE register (operands, rm, requester id) drives the multiplier;
// the product lands in a per-requester RESULT slot one cycle later, so an op
// accepted in cycle N is visible on rsp_valid from cycle N+2.
//
// Handshake: every valid/ready pair transfers on the rising edge where both
// are high. Valid may rise and fall freely. req_ready never looks at the same
// requester's req_valid: it is high when that requester's slot can take a new
// result and no valid, eligible requester ahead of it in round-robin order
// wins this cycle. Only the arbitration winner can see valid&&ready, so at
// most one request transfers per cycle. rsp_z/flags hold while rsp_valid is
// high and rsp_ready is low.
//
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : per-requester request handshake
//   req_x, req_y, req_rm    : per-requester operands and rounding mode
//   rsp_valid/rsp_ready     : per-requester response handshake
//   rsp_z, rsp_ovrf, rsp_udrf : per-requester product and flags
//   mul_x, mul_y, mul_rm    : to the shared multiplier (zero when ISSUE empty)
//   mul_z, mul_ovrf, mul_udrf : from the shared multiplier
//   busy                    : op in ISSUE or any response pending
//
// Build option: define FP_MUL_SCHED_FLAGS_EN to register and return the
// multiplier's overflow/underflow flags; otherwise they read as 0.
module fp_mul_sched
  import fp_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ-1:0][FP32_W-1:0]  req_x,
  input  logic [NREQ-1:0][FP32_W-1:0]  req_y,
  input  logic [NREQ-1:0][RM_W-1:0]    req_rm,
  output logic [NREQ-1:0]              rsp_valid,
  input  logic [NREQ-1:0]              rsp_ready,
  output logic [NREQ-1:0][FP32_W-1:0]  rsp_z,
  output logic [NREQ-1:0]              rsp_ovrf,
  output logic [NREQ-1:0]              rsp_udrf,
  output logic [FP32_W-1:0]            mul_x,
  output logic [FP32_W-1:0]            mul_y,
  output logic [RM_W-1:0]              mul_rm,
  input  logic [FP32_W-1:0]            mul_z,
  input  logic                         mul_ovrf,
  input  logic                         mul_udrf,
  output logic                         busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // ISSUE stage
  logic              iss_valid;
  logic [IDW-1:0]    iss_id;
  logic [FP32_W-1:0] iss_x;
  logic [FP32_W-1:0] iss_y;
  logic [RM_W-1:0]   iss_rm;

  logic [IDW-1:0]    last_grant;

  logic [NREQ-1:0]             slot_valid;
  logic [NREQ-1:0][FP32_W-1:0] slot_z;

  logic [NREQ-1:0] avail;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ahead_blocked;
  logic            accept;
  logic [IDW-1:0]  grant_id;

  // A requester can take a new op when its slot is free (or emptying this
  // cycle) and its previous op is not still sitting in ISSUE. Because the
  // slot is only written one cycle after ISSUE, this also guarantees ISSUE
  // never has to stall.
  always_comb begin
    avail = '0;
    for (int i = 0; i < NREQ; i++) begin
      avail[i] = (!slot_valid[i] || rsp_ready[i]) &&
                 !(iss_valid && (iss_id == IDW'(i)));
    end
  end

  assign eligible = avail & req_valid;

  rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arb (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    accept   = |grant;
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

  // ready[i] is suppressed only by a winner that sits strictly earlier in the
  // current search order. A winner earlier than i never depends on i's own
  // valid, which keeps req_ready[i] free of req_valid[i].
  always_comb begin
    int start;
    int pi;
    int pj;
    ahead_blocked = '0;
    start = int'(last_grant) + 1;
    if (start >= NREQ) start = 0;
    pi = 0;
    pj = 0;
    for (int i = 0; i < NREQ; i++) begin
      pi = i - start;
      if (pi < 0) pi = pi + NREQ;
      for (int j = 0; j < NREQ; j++) begin
        pj = j - start;
        if (pj < 0) pj = pj + NREQ;
        if (grant[j] && (pj < pi)) ahead_blocked[i] = 1'b1;
      end
    end
  end

  // rst_n gates ready so nothing can be accepted while reset is held.
  assign req_ready = avail & ~ahead_blocked & {NREQ{rst_n}};

  // ISSUE loads every cycle: the winning op, or nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid  <= 1'b0;
      iss_id     <= '0;
      iss_x      <= '0;
      iss_y      <= '0;
      iss_rm     <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      iss_valid <= accept;
      if (accept) begin
        iss_id     <= grant_id;
        iss_x      <= req_x[grant_id];
        iss_y      <= req_y[grant_id];
        iss_rm     <= req_rm[grant_id];
        last_grant <= grant_id;
      end
    end
  end

  assign mul_x  = iss_valid ? iss_x  : '0;
  assign mul_y  = iss_valid ? iss_y  : '0;
  assign mul_rm = iss_valid ? iss_rm : '0;

  // RESULT slots. A load takes priority over a drain, which is what lets a
  // slot be consumed and refilled in the same cycle without a bubble.
  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    logic              load;
    logic              v;
    logic [FP32_W-1:0] z;

    assign load = iss_valid && (iss_id == IDW'(i));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        z <= '0;
      end else if (load) begin
        v <= 1'b1;
        z <= mul_z;
      end else if (rsp_ready[i]) begin
        v <= 1'b0;
      end
    end

    assign slot_valid[i] = v;
    assign slot_z[i]     = z;
    assign rsp_z[i]      = v ? z : '0;

`ifdef FP_MUL_SCHED_FLAGS_EN
    logic ovrf;
    logic udrf;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovrf <= 1'b0;
        udrf <= 1'b0;
      end else if (load) begin
        ovrf <= mul_ovrf;
        udrf <= mul_udrf;
      end
    end

    assign rsp_ovrf[i] = v & ovrf;
    assign rsp_udrf[i] = v & udrf;
`else
    assign rsp_ovrf[i] = 1'b0;
    assign rsp_udrf[i] = 1'b0;
`endif
  end

`ifndef FP_MUL_SCHED_FLAGS_EN
  // Flags from the multiplier are deliberately dropped in this build.
  logic unused_mul_flags;
  assign unused_mul_flags = mul_ovrf ^ mul_udrf;
`endif

  assign rsp_valid = slot_valid;
  assign busy      = iss_valid | (|slot_valid);

endmodule

// File: tb/tb_fp_mul_sched.sv
module tb_fp_mul_sched;
  import fp_pkg::*;

  localparam int NREQ = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][31:0]  req_x;
  logic [NREQ-1:0][31:0]  req_y;
  logic [NREQ-1:0][2:0]   req_rm;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [NREQ-1:0][31:0]  rsp_z;
  logic [NREQ-1:0]        rsp_ovrf;
  logic [NREQ-1:0]        rsp_udrf;
  logic [31:0]            mul_x;
  logic [31:0]            mul_y;
  logic [2:0]             mul_rm;
  logic [31:0]            mul_z;
  logic                   mul_ovrf;
  logic                   mul_udrf;
  logic                   busy;

  int checks   = 0;
  int failures = 0;

  fp_mul_sched #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_rm    (req_rm),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_ovrf  (rsp_ovrf),
    .rsp_udrf  (rsp_udrf),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_rm    (mul_rm),
    .mul_z     (mul_z),
    .mul_ovrf  (mul_ovrf),
    .mul_udrf  (mul_udrf),
    .busy      (busy)
  );

  // Truncating fp32 multiply: subnormal inputs count as zero, results
  // beyond the exponent range saturate to inf (ovrf) or flush to zero (udrf).
  // Returns {ovrf, udrf, z}.
  function automatic logic [33:0] fp_model(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] f;
    logic [31:0] z;
    logic        o;
    logic        u;
    s = x[31] ^ y[31];
    o = 1'b0;
    u = 1'b0;
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) begin
      z = {s, 31'd0};
    end else begin
      p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
      e = int'(x[30:23]) + int'(y[30:23]) - 127;
      if (p[47]) begin
        e = e + 1;
        f = p[46:24];
      end else begin
        f = p[45:23];
      end
      if (e >= 255) begin
        o = 1'b1;
        z = {s, 8'hFF, 23'd0};
      end else if (e <= 0) begin
        u = 1'b1;
        z = {s, 31'd0};
      end else begin
        z = {s, e[7:0], f};
      end
    end
    return {o, u, z};
  endfunction

  // Shared multiplier stand-in (rm is only observed, not used).
  always_comb begin
    {mul_ovrf, mul_udrf, mul_z} = fp_model(mul_x, mul_y);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Per requester: expected results of accepted ops, oldest first.
  logic [33:0] exp_q[NREQ][$];
  bit          m_iss_v;
  int          m_iss_id;
  logic [31:0] m_iss_x;
  logic [31:0] m_iss_y;
  logic [2:0]  m_iss_rm;
  bit          m_slot_v[NREQ];
  logic [31:0] m_slot_z[NREQ];
  bit          m_slot_o[NREQ];
  bit          m_slot_u[NREQ];
  int          m_last;

  always @(negedge clk) begin : cmp
    int              win;
    int              k;
    bit              any_slot;
    logic [NREQ-1:0] xfer;
    logic [NREQ-1:0] exp_xfer;
    logic [33:0]     r;
    if (!rst_n) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_z",     64'(rsp_z), 64'd0);
      check("rst_flags",     64'({rsp_ovrf, rsp_udrf}), 64'd0);
      check("rst_mul",       64'({mul_x, mul_y, mul_rm}), 64'd0);
      check("rst_busy",      64'(busy), 64'd0);
      m_iss_v = 1'b0;
      m_last  = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin
        m_slot_v[i] = 1'b0;
        exp_q[i].delete();
      end
    end else begin
      check("mul_x",  64'(mul_x),  64'(m_iss_v ? m_iss_x  : 32'd0));
      check("mul_y",  64'(mul_y),  64'(m_iss_v ? m_iss_y  : 32'd0));
      check("mul_rm", 64'(mul_rm), 64'(m_iss_v ? m_iss_rm : 3'd0));
      any_slot = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        any_slot = any_slot | m_slot_v[i];
        check("rsp_valid", 64'(rsp_valid[i]), 64'(m_slot_v[i]));
        if (m_slot_v[i]) begin
          check("rsp_z", 64'(rsp_z[i]), 64'(m_slot_z[i]));
`ifdef FP_MUL_SCHED_FLAGS_EN
          check("rsp_flags", 64'({rsp_ovrf[i], rsp_udrf[i]}), 64'({m_slot_o[i], m_slot_u[i]}));
`else
          check("rsp_flags", 64'({rsp_ovrf[i], rsp_udrf[i]}), 64'd0);
`endif
        end
      end
      check("busy", 64'(busy), 64'(m_iss_v | any_slot));

      // Round-robin winner among eligible requesters.
      win = -1;
      for (int off = 1; off <= NREQ; off++) begin
        k = (m_last + off) % NREQ;
        if (win < 0 && req_valid[k] && (!m_slot_v[k] || rsp_ready[k]) &&
            !(m_iss_v && m_iss_id == k)) win = k;
      end
      xfer     = req_valid & req_ready;
      exp_xfer = '0;
      if (win >= 0) exp_xfer[win] = 1'b1;
      check("grant", 64'(xfer), 64'(exp_xfer));

      // Advance to the next cycle.
      for (int i = 0; i < NREQ; i++) begin
        if (m_iss_v && m_iss_id == i) begin
          r = exp_q[i].pop_front();
          m_slot_v[i] = 1'b1;
          m_slot_z[i] = r[31:0];
          m_slot_o[i] = r[33];
          m_slot_u[i] = r[32];
        end else if (rsp_ready[i]) begin
          m_slot_v[i] = 1'b0;
        end
      end
      if (win >= 0) begin
        m_iss_v  = 1'b1;
        m_iss_id = win;
        m_iss_x  = req_x[win];
        m_iss_y  = req_y[win];
        m_iss_rm = req_rm[win];
        exp_q[win].push_back(fp_model(req_x[win], req_y[win]));
        m_last   = win;
      end else begin
        m_iss_v = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      req_x[i]  = $urandom;
      req_y[i]  = $urandom;
      req_rm[i] = 3'($urandom_range(0, 7));
    end
  endtask

  // One op on an idle scheduler, rsp_ready all high; pins latency and value.
  task automatic single_op(input int i, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] rm, input logic [31:0] exp_z,
                           input logic exp_o, input string nm);
    tick();
    req_valid    = '0;
    req_valid[i] = 1'b1;
    req_x[i]     = x;
    req_y[i]     = y;
    req_rm[i]    = rm;
    @(negedge clk);
    check({nm, "_ready"}, 64'(req_ready[i]), 64'd1);
    tick();
    req_valid = '0;
    @(negedge clk);
    check({nm, "_lat1_valid"}, 64'(rsp_valid[i]), 64'd0);
    check({nm, "_mul_x"},      64'(mul_x), 64'(x));
    check({nm, "_mul_rm"},     64'(mul_rm), 64'(rm));
    tick();
    @(negedge clk);
    check({nm, "_lat2_valid"}, 64'(rsp_valid[i]), 64'd1);
    check({nm, "_z"},          64'(rsp_z[i]), 64'(exp_z));
    check({nm, "_ovrf"},       64'(rsp_ovrf[i]), 64'(exp_o));
    tick();
    @(negedge clk);
    check({nm, "_drained"},    64'(rsp_valid[i]), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] held_z;
    int          served;
    logic        ovf_exp;
`ifdef FP_MUL_SCHED_FLAGS_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    req_x     = '0;
    req_y     = '0;
    req_rm    = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single op, zero/subnormal, illegal rm, overflow flag.
    single_op(0, 32'h40400000, 32'h40400000, RM_RTZ, 32'h41100000, 1'b0, "three_sq");
    single_op(0, 32'h80000000, 32'h3F800000, RM_RNE, 32'h80000000, 1'b0, "neg_zero");
    single_op(1, 32'h00000001, 32'h3F800000, RM_RNE, 32'h00000000, 1'b0, "subnorm");
    single_op(1, 32'h3FC00000, 32'h40000000, 3'b111, 32'h40400000, 1'b0, "bad_rm");
    single_op(0, 32'h7F000000, 32'h7F000000, RM_RNE, 32'h7F800000, ovf_exp, "ovf");

    // Contention from reset: grants alternate 0,1,0,1.
    tick();
    rst_n     = 1'b0;
    req_valid = '1;
    rand_ops();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("contend_grant", 64'(req_valid & req_ready), 64'((c % 2 == 0) ? 1 : 2));
      if (c >= 2)
        check("contend_rsp", 64'(rsp_valid), 64'((c % 2 == 0) ? 1 : 2));
      tick();
      rand_ops();
    end
    req_valid = '0;
    repeat (3) tick();

    // Backpressure on requester 0 while requester 1 keeps flowing.
    req_valid = '1;
    rsp_ready = 2'b10;
    served    = 0;
    held_z    = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) served++;
      if (c == 3) held_z = rsp_z[0];
      if (c >= 3) begin
        check("bp_ready0", 64'(req_ready[0]), 64'd0);
        check("bp_hold_v", 64'(rsp_valid[0]), 64'd1);
        check("bp_hold_z", 64'(rsp_z[0]), 64'(held_z));
      end
      tick();
      if (c > 0) begin
        req_x[1] = $urandom;
        req_y[1] = $urandom;
      end
    end
    check("bp_req1_served", 64'(served >= 3), 64'd1);
    req_valid = '0;
    rsp_ready = '1;
    repeat (4) tick();

    // Reset one cycle after accept: nothing comes back, req0 wins first.
    req_valid[0] = 1'b1;
    req_x[0]     = 32'h40400000;
    req_y[0]     = 32'h40400000;
    @(negedge clk);
    check("rstmid_accept", 64'(req_ready[0]), 64'd1);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstmid_no_rsp", 64'({busy, rsp_valid}), 64'd0);
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    check("rstmid_first", 64'(req_valid & req_ready), 64'd1);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Randomized traffic with one reset pulse in the middle.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      rand_ops();
    end
    tick();
    req_valid = '0;
    rsp_ready = '1;
    repeat (5) tick();
    @(negedge clk);
    check("final_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
